// File: rtl/axi_dac_jesd204_datasel_if.sv
// Sample-source bus between the channel control/DMA side and the JESD204 data selector.
interface axi_dac_jesd204_datasel_if #(
    parameter int unsigned DATA_PATH_WIDTH = 2,
    parameter int unsigned SEL_WIDTH       = 4
);
    logic                            dac_enable;
    logic [SEL_WIDTH-1:0]            dac_data_sel;
    logic [15:0]                     dac_pat_data;
    logic [16*DATA_PATH_WIDTH-1:0]   dac_dma_data;
    logic                            dac_dma_valid;
    logic                            dac_dma_rd;
    logic                            dac_dunf_clr;
    logic                            dac_dunf;
    logic [16*DATA_PATH_WIDTH-1:0]   dac_data;

    modport master (
        output dac_enable, dac_data_sel, dac_pat_data, dac_dma_data, dac_dma_valid, dac_dunf_clr,
        input  dac_dma_rd, dac_dunf, dac_data
    );

    modport slave (
        input  dac_enable, dac_data_sel, dac_pat_data, dac_dma_data, dac_dma_valid, dac_dunf_clr,
        output dac_dma_rd, dac_dunf, dac_data
    );
endinterface

// File: rtl/axi_dac_jesd204_datasel.sv
// Per-channel DAC sample source: DMA, PN7, PN15, ramp or constant pattern.
// Optional PN15 generator enabled by defining AXI_DAC_JESD204_DATASEL_PN15_EN.
module axi_dac_jesd204_datasel #(
    parameter int unsigned DATA_PATH_WIDTH = 2,
    parameter int unsigned SEL_WIDTH       = 4
) (
    input  logic                         dac_clk,
    input  logic                         dac_rst,
    axi_dac_jesd204_datasel_if.slave     dac
);
    localparam int unsigned DW = 16 * DATA_PATH_WIDTH;
    localparam int unsigned LAST_LSB = 16 * (DATA_PATH_WIDTH - 1);

    localparam logic [SEL_WIDTH-1:0] SEL_DMA   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_PN7   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_RAMP  = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] SEL_CONST = SEL_WIDTH'(4);
    localparam logic [6:0]           PN7_SEED  = 7'h7F;
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
    localparam logic [SEL_WIDTH-1:0] SEL_PN15  = SEL_WIDTH'(2);
    localparam logic [14:0]          PN15_SEED = 15'h7FFF;
`endif

    // Generates DW successive LFSR bits (taps hi, hi-1), MSB first per sample, sample 0 in the LSBs.
    function automatic logic [DW-1:0] pn_seq(input logic [14:0] seed, input logic [3:0] hi);
        logic [14:0]   s;
        logic [DW-1:0] stream;
        logic [DW-1:0] word;
        logic          nb;
        s      = seed;
        stream = '0;
        word   = '0;
        for (int i = 0; i < int'(DW); i++) begin
            nb     = s[hi] ^ s[hi - 4'd1];
            s      = {s[13:0], nb};
            stream = {stream[DW-2:0], nb};
        end
        for (int k = 0; k < int'(DATA_PATH_WIDTH); k++) begin
            word[16*k +: 16] = stream[DW - 16*(k+1) +: 16];
        end
        return word;
    endfunction

    logic [SEL_WIDTH-1:0] sel_d;
    logic [6:0]           pn7_q, pn7_cur, pn7_nxt;
    logic [15:0]          ramp_q, ramp_cur, ramp_nxt;
    logic [DW-1:0]        pn7_word, ramp_word, data_q, data_nxt;
    logic                 dunf_q, dunf_set, sel_chg;
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
    logic [14:0]          pn15_q, pn15_cur, pn15_nxt;
    logic [DW-1:0]        pn15_word;
`endif

    assign dac.dac_dma_rd = dac.dac_enable && (dac.dac_data_sel == SEL_DMA);
    assign dac.dac_data   = data_q;
    assign dac.dac_dunf   = dunf_q;

    // Source mux and generator advance; a select change restarts every generator from its seed.
    always_comb begin
        sel_chg   = (dac.dac_data_sel != sel_d);
        pn7_cur   = sel_chg ? PN7_SEED : pn7_q;
        pn7_word  = pn_seq(15'(pn7_cur), 4'd6);
        ramp_cur  = sel_chg ? 16'd0 : ramp_q;
        ramp_word = '0;
        for (int k = 0; k < int'(DATA_PATH_WIDTH); k++) begin
            ramp_word[16*k +: 16] = ramp_cur + 16'(k);
        end
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
        pn15_cur  = sel_chg ? PN15_SEED : pn15_q;
        pn15_word = pn_seq(pn15_cur, 4'd14);
        pn15_nxt  = pn15_cur;
`endif
        pn7_nxt  = pn7_cur;
        ramp_nxt = ramp_cur;
        data_nxt = '0;
        dunf_set = 1'b0;

        if (dac.dac_enable) begin
            case (dac.dac_data_sel)
                SEL_DMA: begin
                    if (dac.dac_dma_valid) data_nxt = dac.dac_dma_data;
                    else                   dunf_set = 1'b1;
                end
                SEL_PN7: begin
                    data_nxt = pn7_word;
                    // The LFSR state after a word is simply its last 7 emitted bits.
                    pn7_nxt  = pn7_word[LAST_LSB +: 7];
                end
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
                SEL_PN15: begin
                    data_nxt = pn15_word;
                    pn15_nxt = pn15_word[LAST_LSB +: 15];
                end
`endif
                SEL_RAMP: begin
                    data_nxt = ramp_word;
                    ramp_nxt = ramp_cur + 16'(DATA_PATH_WIDTH);
                end
                SEL_CONST: data_nxt = {DATA_PATH_WIDTH{dac.dac_pat_data}};
                default: ;
            endcase
        end
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            sel_d  <= '0;
            pn7_q  <= PN7_SEED;
            ramp_q <= '0;
            data_q <= '0;
            dunf_q <= 1'b0;
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
            pn15_q <= PN15_SEED;
`endif
        end else begin
            sel_d  <= dac.dac_data_sel;
            pn7_q  <= pn7_nxt;
            ramp_q <= ramp_nxt;
            data_q <= data_nxt;
            // Sticky underflow; a new underflow wins over a simultaneous clear.
            dunf_q <= dunf_set | (dunf_q & ~dac.dac_dunf_clr);
`ifdef AXI_DAC_JESD204_DATASEL_PN15_EN
            pn15_q <= pn15_nxt;
`endif
        end
    end
endmodule
